// File: rtl/hdcpu_pkg.sv
// hdcpu_pkg: shared state encoding and ALU/register-select codes for the serial transfer path.
package hdcpu_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
    localparam logic [3:0] ALU_A_PLUS_A = 4'b1100;
    localparam logic [3:0] SEL_R3       = 4'b1111;
endpackage

// File: rtl/bit_counter.sv
// bit_counter: CW-bit up-counter with synchronous clear/enable and a flag on the last shift bit.
module bit_counter #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic          T3,
    input  logic          CLR,
    input  logic          clear,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          last
);
    always_ff @(posedge T3 or negedge CLR)
        if (!CLR) count <= '0;
        else if (clear) count <= '0;
        else if (en) count <= count + 1'b1;
    assign last = count == CW'(WIDTH - 1);
endmodule

// File: rtl/serial_xfer_ctrl.sv
// serial_xfer_ctrl: moves one byte between num and R3 through the ALU carry path, one bit per T3 cycle.
module serial_xfer_ctrl
    import hdcpu_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [3:0]       REG_SEL  = SEL_R3,
    parameter logic [WIDTH-1:0] INIT_VAL = 'hAA,
    parameter int               CW       = 4
) (
    input  logic             T3,
    input  logic             CLR,
    input  logic             start,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             C,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] num,
    output logic [CW-1:0]    count,
    output logic [3:0]       S,
    output logic             M,
    output logic             CIN,
    output logic             ABUS,
    output logic             DRW,
    output logic             LDC,
    output logic             LDZ,
    output logic             SELCTL,
    output logic             SHORT,
    output logic             STOP,
    output logic [3:0]       SEL
);
    state_t           state, state_next;
    logic             dir_q, last, shift, fin, capture, inj_bit;
    logic [CW-1:0]    cap_idx;
    logic [WIDTH-1:0] num_next;

    bit_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
        .T3(T3), .CLR(CLR), .clear(!shift), .en(shift), .count(count), .last(last)
    );

    always_ff @(posedge T3 or negedge CLR)
        if (!CLR) begin
            state <= IDLE;
            dir_q <= 1'b0;
            num   <= INIT_VAL;
        end else begin
            state <= state_next;
            num   <= num_next;
            if (state == IDLE && start) dir_q <= dir;
        end

    // C lags each doubling by one cycle, so bit WIDTH-k lands while count=k and bit 0 in FINISH
    always_comb begin
        state_next = (state == IDLE && start) ? SHIFT :
                     (state == SHIFT && last) ? FINISH :
                     (state == FINISH)        ? IDLE : state;
        shift    = state == SHIFT;
        fin      = state == FINISH;
        cap_idx  = CW'(WIDTH) - count;
        capture  = !dir_q && ((shift && count != '0) || fin);
        num_next = (state == IDLE && !start && load) ? load_val : num;
        inj_bit  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (capture && cap_idx == CW'(i)) num_next[i] = C;
            if (count == CW'(WIDTH - 1 - i)) inj_bit = num[i];
        end
    end

    assign busy   = state != IDLE;
    assign done   = fin;
    assign STOP   = fin;
    assign SHORT  = shift | fin;
    assign SELCTL = shift;
    assign ABUS   = shift;
    assign DRW    = shift;
    assign LDC    = shift;
    assign LDZ    = shift;
    assign M      = 1'b0;
    assign S      = shift ? ALU_A_PLUS_A : 4'h0;
    assign SEL    = shift ? REG_SEL : 4'h0;
    assign CIN    = (shift && dir_q) ? ~inj_bit : 1'b1;
endmodule

// File: tb/tb_serial_xfer_ctrl.sv
// tb_serial_xfer_ctrl: directed bench with an R3/carry datapath model driving C from the DUT controls.
module tb_serial_xfer_ctrl;
    logic       T3 = 1'b0, CLR = 1'b1, start = 1'b0, dir = 1'b0, load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic       C;
    logic       busy, done, M, CIN, ABUS, DRW, LDC, LDZ, SELCTL, SHORT, STOP;
    logic [7:0] num;
    logic [3:0] count, S, SEL;

    logic [7:0] r3 = 8'h00, r3_init = 8'h00;
    logic       c_q = 1'b0, r3_wr = 1'b0;
    int         checks = 0, errors = 0;

    localparam logic [18:0] IDLE_CTL  = {4'h0, 1'b0, 4'h0, 10'b0000000100};
    localparam logic [18:0] SHIFT_CAP = {4'hC, 1'b0, 4'hF, 10'b1111110101};
    localparam logic [18:0] FIN_CTL   = {4'h0, 1'b0, 4'h0, 10'b0000011111};
    logic [18:0] ctl;
    assign ctl = {S, M, SEL, ABUS, DRW, LDC, LDZ, SELCTL, SHORT, STOP, CIN, done, busy};

    serial_xfer_ctrl dut (
        .T3(T3), .CLR(CLR), .start(start), .dir(dir), .load(load), .load_val(load_val), .C(C),
        .busy(busy), .done(done), .num(num), .count(count), .S(S), .M(M), .CIN(CIN),
        .ABUS(ABUS), .DRW(DRW), .LDC(LDC), .LDZ(LDZ), .SELCTL(SELCTL), .SHORT(SHORT),
        .STOP(STOP), .SEL(SEL)
    );

    always #5 T3 = ~T3;

    // Datapath model: R3 <= R3 + R3 + carry-in, carry-out registered into C
    assign C = c_q;
    always @(posedge T3)
        if (r3_wr) r3 <= r3_init;
        else if (DRW && LDC) {c_q, r3} <= {1'b0, r3} + {1'b0, r3} + 9'(!CIN);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic set_r3(input logic [7:0] v);
        @(negedge T3);
        r3_wr = 1'b1;
        r3_init = v;
        @(negedge T3);
        r3_wr = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(negedge T3);
            n++;
        end
    endtask

    task automatic capture(input logic [7:0] v, input string tag);
        int n;
        set_r3(v);
        @(negedge T3);
        start = 1'b1;
        dir = 1'b0;
        @(negedge T3);
        start = 1'b0;
        wait_done(n);
        chk({tag, "_lat"}, n, 8);
        @(negedge T3);
        chk({tag, "_num"}, num, v);
    endtask

    logic [7:0] inj_exp = 8'b0110_1100;
    int n, dones;

    initial begin
        #1 CLR = 1'b0;
        repeat (2) @(negedge T3);
        chk("rst_ctl", ctl, IDLE_CTL);
        chk("rst_num", num, 8'hAA);
        chk("rst_cnt", count, 0);
        CLR = 1'b1;

        set_r3(8'h5C);
        @(negedge T3);
        start = 1'b1;
        dir = 1'b0;
        @(negedge T3);
        start = 1'b0;
        chk("cap_shift_ctl", ctl, SHIFT_CAP);
        chk("cap_cnt0", count, 0);
        wait_done(n);
        chk("cap_lat", n, 8);
        chk("cap_fin_ctl", ctl, FIN_CTL);
        chk("cap_fin_cnt", count, 8);
        @(negedge T3);
        chk("cap_num", num, 8'h5C);
        chk("cap_r3", r3, 8'h00);
        chk("cap_idle_ctl", ctl, IDLE_CTL);

        @(negedge T3);
        load = 1'b1;
        load_val = 8'h93;
        @(negedge T3);
        load = 1'b0;
        chk("load_num", num, 8'h93);
        set_r3(8'hFF);
        @(negedge T3);
        start = 1'b1;
        dir = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge T3);
            start = 1'b0;
            chk("inj_cin", CIN, inj_exp[7-i]);
        end
        @(negedge T3);
        chk("inj_done", done, 1);
        chk("inj_r3", r3, 8'h93);
        chk("inj_num", num, 8'h93);

        set_r3(8'h3C);
        @(negedge T3);
        start = 1'b1;
        dir = 1'b0;
        dones = 0;
        for (int i = 0; i <= 8; i++) begin
            @(negedge T3);
            start = (i == 3 || i == 8);
            dir = (i >= 2);
            chk("col_cnt", count, i);
            dones += int'(done);
        end
        @(negedge T3);
        start = 1'b0;
        dir = 1'b0;
        chk("col_idle", busy, 0);
        chk("col_dones", dones, 1);
        chk("col_num", num, 8'h3C);

        @(negedge T3);
        start = 1'b1;
        load = 1'b1;
        load_val = 8'hFF;
        dir = 1'b1;
        @(negedge T3);
        start = 1'b0;
        load = 1'b0;
        dir = 1'b0;
        chk("sl_busy", busy, 1);
        chk("sl_num_kept", num, 8'h3C);
        wait_done(n);
        chk("sl_lat", n, 8);
        chk("sl_r3", r3, 8'h3C);
        chk("sl_num", num, 8'h3C);

        set_r3(8'h77);
        @(negedge T3);
        start = 1'b1;
        dir = 1'b0;
        @(negedge T3);
        start = 1'b0;
        n = 0;
        while (count != 4 && n < 20) begin
            @(negedge T3);
            n++;
        end
        chk("mid_cnt4", count, 4);
        CLR = 1'b0;
        #1;
        chk("mid_rst_ctl", ctl, IDLE_CTL);
        chk("mid_rst_num", num, 8'hAA);
        chk("mid_rst_cnt", count, 0);
        @(negedge T3);
        CLR = 1'b1;
        capture(8'h01, "post_rst");

        set_r3(8'hA5);
        @(negedge T3);
        start = 1'b1;
        dir = 1'b0;
        @(negedge T3);
        wait_done(n);
        chk("b2b_lat1", n, 8);
        @(negedge T3);
        chk("b2b_gap", busy, 0);
        chk("b2b_num1", num, 8'hA5);
        @(negedge T3);
        start = 1'b0;
        chk("b2b_restart", busy, 1);
        chk("b2b_cnt0", count, 0);
        wait_done(n);
        chk("b2b_lat2", n, 8);
        @(negedge T3);
        chk("b2b_num2", num, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_xfer_ctrl.md
Name: serial_xfer_ctrl

Overview:
- Sequencer that moves one byte between an internal holding register `num` and a CPU register, through the ALU carry path, one bit per T3 cycle.
- Capture mode (register → `num`): doubles the register with A+A and samples C MSB-first.
- Inject mode (`num` → register): rebuilds the register by shifting `num` bits in through CIN.
- Sits beside the hardwired controller. It owns ALU/register-file control while `busy`; the controller ORs these outputs into its own and holds off its own drive.

Parameters:
- WIDTH, 8, bits per transfer and width of `num`.
- REG_SEL, 4'b1111, SEL value applied during transfer (RD=RS=R3).
- INIT_VAL, 8'hAA, reset value of `num`.
- CW, 4, counter width; must satisfy 2**CW > WIDTH.

Ports:
- T3  input  1  system clock; all state updates on posedge.
- CLR  input  1  asynchronous active-low reset.
- start  input  1  begin transfer; sampled in IDLE only.
- dir  input  1  0 = capture (reg→num), 1 = inject (num→reg); latched at start.
- load  input  1  synchronous write of `load_val` into `num`; IDLE only.
- load_val  input  WIDTH  value for load.
- C  input  1  ALU carry flag, registered by the datapath.
- busy  output  1  transfer in progress (SHIFT or FINISH).
- done  output  1  one-cycle pulse in FINISH.
- num  output  WIDTH  holding register.
- count  output  CW  current bit counter.
- S  output  4  ALU function.
- M  output  1  ALU mode.
- CIN  output  1  active-low carry-in (1 = no carry).
- ABUS, DRW, LDC, LDZ, SELCTL, SHORT, STOP  output  1 each  datapath/timing controls.
- SEL  output  4  register select.

Behaviour:
- Reset (CLR=0, async): state=IDLE, count=0, dir_q=0, num=INIT_VAL. busy=done=0. All control outputs 0, except CIN=1.
- States: IDLE, SHIFT, FINISH. Transitions:
  - IDLE: start=1 → SHIFT, count=0, dir_q=dir.
  - IDLE: start=0 and load=1 → num=load_val. If start and load are both 1, start wins and load is dropped.
  - SHIFT: count<WIDTH-1 → count+1. At count=WIDTH-1 → FINISH, count=WIDTH.
  - FINISH: → IDLE, count=0. A start arriving in FINISH is ignored; it must be re-presented in IDLE.
- SHIFT outputs (both modes), combinational from state/count/dir_q:
  - SELCTL=1, SEL=REG_SEL, S=4'b1100, M=0, ABUS=1, DRW=1, LDC=1, LDZ=1, SHORT=1.
  - The result is reg ← reg+reg+cin.
- Capture (dir_q=0):
  - CIN=1 throughout.
  - C reflects the bit shifted out one cycle after each doubling.
  - At posedge ending SHIFT with count=k≥1: num[WIDTH-k] ← C. At posedge ending FINISH: num[0] ← C.
  - Result: after FINISH, num equals the original register value MSB-first. The register ends as 0 (mod 2^WIDTH).
- Inject (dir_q=1):
  - CIN = ~num[WIDTH-1-count] during SHIFT.
  - After WIDTH SHIFT cycles the register equals num, regardless of its prior value. num is unchanged.
- FINISH outputs: done=1, STOP=1, SHORT=1, all ALU/regfile writes 0 (DRW=LDC=LDZ=ABUS=0, SELCTL=0, CIN=1).
- IDLE outputs: all controls 0, CIN=1.
- busy=1 in SHIFT and FINISH. dir, load and load_val are ignored while busy.
- Latency: start accepted at edge 0 → SHIFT cycles 1..WIDTH → FINISH cycle WIDTH+1 → IDLE. Total WIDTH+1 cycles busy.
- Reset mid-transfer: immediate abort to IDLE, num=INIT_VAL. The CPU register keeps its partial value; no recovery is attempted.
- No combinational path from C to any output. C only feeds `num`.

Decomposition:
- Shared package `hdcpu_pkg`: state enum (IDLE/SHIFT/FINISH), ALU codes (ALU_A_PLUS_A=4'b1100), SEL_R3=4'b1111.
- Sub-module `bit_counter`: CW-bit up-counter with clear/enable and terminal flag at WIDTH-1.
- Output decode stays in the top module.

Test Plan:
- Reset value: assert CLR=0 mid-run → num=8'hAA, busy=0, CIN=1, all other controls 0 within the same cycle (async).
- Capture: model R3=8'h5C with ALU/C model, pulse start with dir=0 → 8 SHIFT cycles, done on cycle 9, num=8'h5C, R3=0.
- Inject: load num=8'h93, R3=8'hFF, start with dir=1 → CIN sequence (active-low) 0,1,1,0,1,1,0,0; R3=8'h93 at done; num still 8'h93.
- Collisions: start during SHIFT and FINISH → ignored, count monotonic, exactly one done. start+load together in IDLE → transfer begins, num not loaded.
- Reset mid-transfer: CLR low at count=4 → IDLE, count=0, num=8'hAA. A subsequent capture of 8'h01 yields num=8'h01.
- Back-to-back: start held high → a new transfer begins the cycle after FINISH (IDLE for one cycle). dir changes mid-transfer have no effect.
